pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline-boundary register. It is the generic successor to the fixed-field inter-stage latches (IFID/IDEX/EXMEM/MEMWB).
- Carries an opaque DATA_W-bit payload plus a halt bit across a stage boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is registered and breaks the combinational stall path.
- Keeps the legacy enable/flush controls, so the hazard unit can drive it unchanged.

Parameters:
- DATA_W, 32: payload width in bits; legal range 1..512.
- BUBBLE_VAL, 0: value driven on out_data whenever out_valid=0. Width DATA_W, zero-extended/truncated.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- enable  in  1  legacy stall. 0 is treated exactly as out_ready=0 for this cycle.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  payload is a halt instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  DATA_W  head payload, or BUBBLE_VAL when not valid.
- out_halt  out  1  halt bit of the head entry; 0 when not valid.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  32  see Optional Feature.
- flush_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (RST=1 at an edge):
  - occupancy=0, out_valid=0, out_data=BUBBLE_VAL, out_halt=0.
  - in_ready=1, halt_seen=0, counters=0.
  - Reset overrides flush, enable and any handshake. Reset mid-transfer discards both entries.
- Definitions:
  - acc = in_valid & in_ready
  - deq = out_valid & out_ready & enable
  - All handshakes are sampled at the rising edge.
- State machine on occupancy:
  - EMPTY: acc → ONE (head←in).
  - ONE:
    - acc & deq → ONE (head←in).
    - acc & !deq → TWO (skid←in).
    - !acc & deq → EMPTY.
  - TWO (in_ready=0, so no acc):
    - deq → ONE (head←skid).
    - otherwise hold.
- in_ready next-state: 1 iff the next occupancy is < 2 and halt_seen is 0.
- Latency: 1 cycle from acc to out_valid when EMPTY. Throughput is one transfer per cycle when out_ready is held high.
- Order: strictly FIFO; the skid entry never overtakes the head.
- Flush (RST=0):
  - Next state is EMPTY and out_data becomes BUBBLE_VAL.
  - A same-cycle acc is discarded; upstream saw in_ready=1 and considers it transferred.
  - A same-cycle deq still counts as delivered downstream.
  - Flush clears halt_seen.
- Halt:
  - acc with in_halt=1 sets sticky halt_seen.
  - From the next cycle, in_ready=0 until flush or reset.
  - Entries already held still drain normally.
- enable=0 with flush=1: flush wins.
- out_data and out_halt are flop outputs; no combinational path from in_* to out_*.
- Payload bits are never inspected or modified.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments when out_valid & !(out_ready & enable).
  - flush_cnt increments on each cycle with flush=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared only by RST.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are synthesised.

Test Plan:
- Streaming: out_ready=1, 8 back-to-back payloads 0x1..0x8 → out_data 0x1..0x8 on consecutive cycles, 1 cycle after each acc; occupancy never exceeds 1.
- Backpressure: out_ready=0 while sending 0xA, 0xB, 0xC → 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream. Then release → outputs 0xA, 0xB, 0xC in order.
- Flush while full (occupancy=2) plus same-cycle in_valid with 0xD → next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL, 0xD never appears.
- Halt: accept 0x5 with in_halt=1 → in_ready=0 the following cycle and stays 0 for 10 cycles; 0x5 is delivered with out_halt=1; a flush restores in_ready=1.
- Legacy stall: out_ready=1, enable=0 for 3 cycles while holding 0x7 → out_data stays 0x7, no deq. With PIPE_STAGE_PERF_EN, stall_cnt=3.
- Reset mid-operation: occupancy=2, then RST=1 for one cycle → all outputs at their reset values the next cycle, counters=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline-boundary register with a valid/ready handshake and a 2-entry skid buffer.
// Optional stall/flush performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic [1:0]        occupancy,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HEAD_HOLD = 2'd0,
        HEAD_IN   = 2'd1,
        HEAD_SKID = 2'd2,
        HEAD_CLR  = 2'd3
    } head_op_t;

    state_t            r_state;
    state_t            w_state_nxt;
    head_op_t          w_head_op;
    logic              w_skid_load;
    logic              w_acc;
    logic              w_deq;
    logic              w_halt_seen_nxt;

    logic [DATA_W-1:0] r_head_data;
    logic              r_head_halt;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_halt;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_halt_seen;

    assign w_acc = in_valid & r_in_ready;
    assign w_deq = r_out_valid & out_ready & enable;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush squashes everything regardless of handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_ONE;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_deq) begin
                        w_state_nxt = ST_TWO;
                    end else if (!w_acc && w_deq) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        w_state_nxt = ST_ONE;
                    end else begin
                        w_state_nxt = ST_TWO;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Datapath steering derived from the current state and handshakes.
    always_comb begin
        w_head_op   = HEAD_HOLD;
        w_skid_load = 1'b0;
        if (flush) begin
            w_head_op = HEAD_CLR;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_head_op = HEAD_IN;
                    end else begin
                        w_head_op = HEAD_HOLD;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_deq) begin
                        w_head_op = HEAD_IN;
                    end else if (w_acc) begin
                        w_skid_load = 1'b1;
                    end else if (w_deq) begin
                        w_head_op = HEAD_CLR;
                    end else begin
                        w_head_op = HEAD_HOLD;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        w_head_op = HEAD_SKID;
                    end else begin
                        w_head_op = HEAD_HOLD;
                    end
                end
                default: begin
                    w_head_op = HEAD_CLR;
                end
            endcase
        end
    end

    // Sticky halt: set by accepting a halt payload, cleared only by flush/reset.
    always_comb begin
        if (flush) begin
            w_halt_seen_nxt = 1'b0;
        end else if (w_acc && in_halt) begin
            w_halt_seen_nxt = 1'b1;
        end else begin
            w_halt_seen_nxt = r_halt_seen;
        end
    end

    // Head entry; empty head always carries the bubble so out_data needs no mux.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head_data <= BUBBLE_VAL;
            r_head_halt <= 1'b0;
        end else begin
            case (w_head_op)
                HEAD_IN: begin
                    r_head_data <= in_data;
                    r_head_halt <= in_halt;
                end
                HEAD_SKID: begin
                    r_head_data <= r_skid_data;
                    r_head_halt <= r_skid_halt;
                end
                HEAD_CLR: begin
                    r_head_data <= BUBBLE_VAL;
                    r_head_halt <= 1'b0;
                end
                default: begin
                    r_head_data <= r_head_data;
                    r_head_halt <= r_head_halt;
                end
            endcase
        end
    end

    // Skid entry; contents are don't-care unless the state is TWO.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_skid_data <= '0;
            r_skid_halt <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_data <= in_data;
            r_skid_halt <= in_halt;
        end else begin
            r_skid_data <= r_skid_data;
            r_skid_halt <= r_skid_halt;
        end
    end

    // Registered handshake outputs, so upstream never sees a combinational stall path.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_halt_seen <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_TWO) && !w_halt_seen_nxt;
            r_halt_seen <= w_halt_seen_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_head_data;
    assign out_halt  = r_head_halt;
    assign occupancy = r_state;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall;

    assign w_stall = r_out_valid & !(out_ready & enable);

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
